pll_sweep_ctrl: RTL and testbench

Sequencer that drives the 8-bit freq_param input of the PseudoPll divider. In idle it passes a manual setting through. On command it steps freq_param from a start code to a stop code in programmable increments, holding each code for a programmable number of clk_in cycles. Supports one-shot, looping and triangle (up-and-back) sweeps. It sits between the control/UI logic and the PseudoPll instance, in the same clk_in domain.

---
 rtl/pll_ctrl_pkg.sv | 14 +
 rtl/pll_step_calc.sv | 40 ++++
 rtl/pll_sweep_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pll_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared widths and state encoding for the PseudoPll frequency sweep sequencer.
package pll_ctrl_pkg;

  localparam int PARAM_W_DEFAULT = 8;
  localparam int DWELL_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pll_step_calc.sv
// Next sweep code: one step from cur toward target, saturated at the target so
// the code never overshoots or wraps through 0 / all-ones.
module pll_step_calc
  import pll_ctrl_pkg::*;
#(
  parameter int PARAM_W = PARAM_W_DEFAULT
) (
  input  logic [PARAM_W-1:0] cur,
  input  logic [PARAM_W-1:0] target,
  input  logic [PARAM_W-1:0] step,
  input  logic               dir_down,
  output logic [PARAM_W-1:0] next_code,
  output logic               at_target
);

  typedef logic [PARAM_W:0] ext_t;

  function automatic logic [PARAM_W-1:0] sat_up(input ext_t sum, input ext_t tgt);
    return (sum >= tgt) ? tgt[PARAM_W-1:0] : sum[PARAM_W-1:0];
  endfunction

  // The extra MSB of diff flags a borrow, i.e. a step that went below zero.
  function automatic logic [PARAM_W-1:0] sat_down(input ext_t diff, input ext_t tgt);
    return (diff[PARAM_W] || (diff <= tgt)) ? tgt[PARAM_W-1:0] : diff[PARAM_W-1:0];
  endfunction

  ext_t cur_x;
  ext_t tgt_x;
  ext_t step_x;

  always_comb begin
    cur_x     = {1'b0, cur};
    tgt_x     = {1'b0, target};
    step_x    = {1'b0, step};
    at_target = (cur == target);
    if (dir_down) next_code = sat_down(cur_x - step_x, tgt_x);
    else          next_code = sat_up(cur_x + step_x, tgt_x);
  end

endmodule

// File: rtl/pll_sweep_ctrl.sv
// Frequency-code sequencer for the PseudoPll: manual pass-through when idle,
// stepped one-shot / looping / triangle sweeps on command.
module pll_sweep_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PARAM_W = PARAM_W_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PARAM_W-1:0] manual_param,
  input  logic [PARAM_W-1:0] start_param,
  input  logic [PARAM_W-1:0] stop_param,
  input  logic [PARAM_W-1:0] step,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               loop_en,
  input  logic               tri_en,
  output logic [PARAM_W-1:0] freq_param,
  output logic               busy,
  output logic               done,
  output logic               param_strobe,
  output logic               dir_down
);

  state_t state, state_nx;

  logic [PARAM_W-1:0] sh_start, sh_stop, sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  logic               sh_loop, sh_tri;
  logic [PARAM_W-1:0] target, target_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic               out_leg, out_leg_nx;

  logic [PARAM_W-1:0] freq_nx;
  logic               busy_nx, done_nx, strobe_nx, dir_nx;

  logic [PARAM_W-1:0] step_eff;
  logic [DWELL_W-1:0] dwell_eff;
  logic [PARAM_W-1:0] other_end;
  logic [PARAM_W-1:0] fwd_next, rev_next;
  logic               at_target, rev_at;
  logic               expire, bounce_ok, sweeping;

  always_comb begin
    step_eff  = (step == '0) ? PARAM_W'(1) : step;
    dwell_eff = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    other_end = out_leg ? sh_start : sh_stop;
    sweeping  = (state == ST_LOAD) || (state == ST_DWELL);
    expire    = (cnt == DWELL_W'(1));
    // A reversal whose far end equals the current code (start == stop) would
    // only re-show the same point, so it is treated as the end of the sweep.
    bounce_ok = sh_tri && (out_leg || sh_loop) && !rev_at;
  end

  pll_step_calc #(.PARAM_W(PARAM_W)) u_fwd (
    .cur       (freq_param),
    .target    (target),
    .step      (sh_step),
    .dir_down  (dir_down),
    .next_code (fwd_next),
    .at_target (at_target)
  );

  pll_step_calc #(.PARAM_W(PARAM_W)) u_rev (
    .cur       (freq_param),
    .target    (other_end),
    .step      (sh_step),
    .dir_down  (~dir_down),
    .next_code (rev_next),
    .at_target (rev_at)
  );

  // ---- state register
  always_ff @(posedge clk_in) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // ---- next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD, ST_DWELL: begin
        if (abort) state_nx = ST_IDLE;
        else if (expire && at_target && !bounce_ok && !sh_loop) state_nx = ST_DONE;
        else state_nx = ST_DWELL;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // ---- output / datapath next values (registered below, so outputs change
  //      on the same edge as the state they belong to)
  always_comb begin
    freq_nx    = freq_param;
    target_nx  = target;
    cnt_nx     = cnt;
    out_leg_nx = out_leg;
    busy_nx    = busy;
    done_nx    = 1'b0;
    strobe_nx  = 1'b0;
    dir_nx     = dir_down;
    unique case (state)
      ST_IDLE: begin
        freq_nx = manual_param;
        busy_nx = 1'b0;
        if (start) begin
          freq_nx    = start_param;
          strobe_nx  = 1'b1;
          busy_nx    = 1'b1;
          cnt_nx     = dwell_eff;
          target_nx  = stop_param;
          dir_nx     = (stop_param < start_param);
          out_leg_nx = 1'b1;
        end
      end
      ST_LOAD, ST_DWELL: begin
        if (abort) begin
          freq_nx = manual_param;
          busy_nx = 1'b0;
        end else if (!expire) begin
          cnt_nx = cnt - DWELL_W'(1);
        end else begin
          cnt_nx = sh_dwell;
          if (!at_target) begin
            freq_nx   = fwd_next;
            strobe_nx = 1'b1;
          end else if (bounce_ok) begin
            freq_nx    = rev_next;
            strobe_nx  = 1'b1;
            target_nx  = other_end;
            dir_nx     = ~dir_down;
            out_leg_nx = ~out_leg;
          end else if (sh_loop && !sh_tri) begin
            freq_nx   = sh_start;
            strobe_nx = 1'b1;
          end else if (!sh_loop) begin
            busy_nx = 1'b0;
            done_nx = 1'b1;
          end
        end
      end
      ST_DONE: busy_nx = 1'b0;
      default: busy_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      freq_param   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      param_strobe <= 1'b0;
      dir_down     <= 1'b0;
      out_leg      <= 1'b0;
    end else begin
      freq_param   <= freq_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      param_strobe <= strobe_nx;
      dir_down     <= dir_nx;
      out_leg      <= out_leg_nx;
    end
  end

  // Shadow copies are captured only when a sweep is accepted.
  always_ff @(posedge clk_in) begin
    cnt    <= cnt_nx;
    target <= target_nx;
    if (state == ST_IDLE && start) begin
      sh_start <= start_param;
      sh_stop  <= stop_param;
      sh_step  <= step_eff;
      sh_dwell <= dwell_eff;
      sh_loop  <= loop_en;
      sh_tri   <= tri_en;
    end
  end

endmodule

// File: tb/tb_pll_sweep_ctrl.sv
// Self-checking bench for pll_sweep_ctrl against a list-of-codes sweep model.
module tb_pll_sweep_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  manual_param;
  logic [7:0]  start_param;
  logic [7:0]  stop_param;
  logic [7:0]  step;
  logic [23:0] dwell_cycles;
  logic        loop_en;
  logic        tri_en;
  logic [7:0]  freq_param;
  logic        busy;
  logic        done;
  logic        param_strobe;
  logic        dir_down;

  int checks = 0;
  int errors = 0;

  int exp_code[$];
  bit exp_dir[$];

  pll_sweep_ctrl dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .manual_param (manual_param),
    .start_param  (start_param),
    .stop_param   (stop_param),
    .step         (step),
    .dwell_cycles (dwell_cycles),
    .loop_en      (loop_en),
    .tri_en       (tri_en),
    .freq_param   (freq_param),
    .busy         (busy),
    .done         (done),
    .param_strobe (param_strobe),
    .dir_down     (dir_down)
  );

  always #5 clk_in = ~clk_in;

  // Walk from a toward b in steps of stp, never passing b.
  task automatic add_leg(input int a, input int b, input int stp, input bit skip_first, input bit d);
    int c;
    c = a;
    if (!skip_first) begin exp_code.push_back(c); exp_dir.push_back(d); end
    while (c != b) begin
      if (b > c) c = (c + stp > b) ? b : c + stp;
      else       c = (c - stp < b) ? b : c - stp;
      exp_code.push_back(c);
      exp_dir.push_back(d);
    end
  endtask

  task automatic build_model(input int s, input int e, input int st, input bit tri_m,
                             input bit loop_m, input int min_len);
    int stp;
    bit d0, outbound;
    stp = (st == 0) ? 1 : st;
    d0  = (e < s);
    exp_code.delete();
    exp_dir.delete();
    add_leg(s, e, stp, 1'b0, d0);
    if (loop_m) begin
      outbound = 1'b1;
      while (exp_code.size() < min_len) begin
        if (tri_m) begin
          if (outbound) add_leg(e, s, stp, 1'b1, !d0);
          else          add_leg(s, e, stp, 1'b1, d0);
          outbound = !outbound;
        end else begin
          add_leg(s, e, stp, 1'b0, d0);
        end
      end
    end else if (tri_m && s != e) begin
      add_leg(e, s, stp, 1'b1, !d0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; manual_param = 8'd77;
    start_param = 0; stop_param = 0; step = 0; dwell_cycles = 0; loop_en = 0; tri_en = 0;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (freq_param !== 8'd0) begin
      errors++; $display("FAIL reset_freq got %0d want 0", freq_param);
    end
    checks++;
    if ({busy, done, param_strobe, dir_down} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, param_strobe, dir_down});
    end
    reset = 1'b0;
    @(posedge clk_in); #1;
    checks++;
    if (freq_param !== 8'd77 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_manual got %0d busy %b want 77 busy 0", freq_param, busy);
    end
  endtask

  // One sweep from a start pulse; abort_at > 0 raises abort during that cycle.
  task automatic test_sweep(input string name, input int s, input int e, input int st,
                            input int dw, input bit tri_m, input bit loop_m,
                            input int abort_at, input int man);
    int d, total, idx, last_code;
    bit last_dir;
    logic [7:0] man_v;
    d = (dw == 0) ? 1 : dw;
    build_model(s, e, st, tri_m, loop_m, (abort_at / d) + 2);
    total     = loop_m ? (1 << 30) : exp_code.size() * d;
    last_code = exp_code[exp_code.size() - 1];
    last_dir  = exp_dir[exp_dir.size() - 1];
    man_v     = man[7:0];
    start_param = s[7:0]; stop_param = e[7:0]; step = st[7:0]; dwell_cycles = dw[23:0];
    tri_en = tri_m; loop_en = loop_m; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    manual_param = man_v;
    start_param  = 8'($urandom); stop_param = 8'($urandom); step = 8'($urandom);
    dwell_cycles = 24'($urandom_range(0, 9)); tri_en = 1'($urandom); loop_en = 1'($urandom);
    for (int k = 1; k <= total + 3; k++) begin
      if (k <= total) begin
        idx = (k - 1) / d;
        checks++;
        if (freq_param !== 8'(exp_code[idx])) begin
          errors++; $display("FAIL %s code k=%0d got %0d want %0d", name, k, freq_param, exp_code[idx]);
        end
        checks++;
        if ({busy, done, param_strobe, dir_down} !== {1'b1, 1'b0, ((k - 1) % d) == 0, exp_dir[idx]}) begin
          errors++;
          $display("FAIL %s flags k=%0d busy/done/strobe/dir got %b want %b", name, k,
                   {busy, done, param_strobe, dir_down},
                   {1'b1, 1'b0, ((k - 1) % d) == 0, exp_dir[idx]});
        end
        if (k == abort_at) begin
          abort = 1'b1;
          @(posedge clk_in); #1;
          abort = 1'b0; start = 1'b0;
          checks++;
          if (freq_param !== man_v || {busy, done, param_strobe} !== 3'b000) begin
            errors++;
            $display("FAIL %s abort got code %0d b/d/s %b want %0d 000", name, freq_param,
                     {busy, done, param_strobe}, man_v);
          end
          @(posedge clk_in); #1;
          checks++;
          if (done !== 1'b0 || busy !== 1'b0 || freq_param !== man_v) begin
            errors++; $display("FAIL %s post_abort got done %b busy %b code %0d", name, done, busy, freq_param);
          end
          return;
        end
        // A second start while the sweep runs must be ignored.
        if (k == 2) start = 1'b1;
      end else if (k == total + 1) begin
        checks++;
        if (freq_param !== 8'(last_code) || {busy, done, param_strobe, dir_down} !== {3'b010, last_dir}) begin
          errors++;
          $display("FAIL %s done_cycle got code %0d flags %b want %0d %b", name, freq_param,
                   {busy, done, param_strobe, dir_down}, last_code, {3'b010, last_dir});
        end
      end else if (k == total + 2) begin
        checks++;
        if (freq_param !== 8'(last_code) || {busy, done, param_strobe} !== 3'b000) begin
          errors++; $display("FAIL %s after_done got code %0d flags %b want %0d 000", name, freq_param,
                             {busy, done, param_strobe}, last_code);
        end
      end else begin
        checks++;
        if (freq_param !== man_v || busy !== 1'b0) begin
          errors++; $display("FAIL %s back_to_manual got %0d want %0d", name, freq_param, man_v);
        end
      end
      @(posedge clk_in); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_directed();
    test_sweep("basic",      10,  30, 10, 4, 0, 0, 0, 12);
    test_sweep("clamp_up",  250, 255,  4, 1, 0, 0, 0, 200);
    test_sweep("clamp_down", 30,  10,  7, 1, 0, 0, 0, 1);
    test_sweep("triangle",   10,  30, 10, 2, 1, 0, 0, 55);
    test_sweep("degenerate",  3,   5,  0, 0, 0, 0, 0, 8);
    test_sweep("single_pt",  42,  42,  5, 3, 0, 0, 0, 9);
    test_sweep("single_tri", 42,  42,  5, 3, 1, 0, 0, 9);
    test_sweep("wrap_down",   5,   0, 200, 1, 1, 0, 0, 3);
  endtask

  task automatic test_loop_abort();
    test_sweep("loop_abort", 5, 7, 1, 1, 0, 1, 5, 99);
    test_sweep("tri_loop",  10, 30, 10, 2, 1, 1, 17, 64);
    test_sweep("abort_one", 20, 90, 35, 3, 0, 0, 4, 17);
  endtask

  task automatic test_random();
    int s, e, st, dw, ab;
    bit t, l;
    for (int n = 0; n < 24; n++) begin
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      st = (n % 3 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      if (st < 8 && ((s > e) ? s - e : e - s) > 40) e = s + ((e > s) ? 40 : -40);
      dw = $urandom_range(0, 3);
      t  = 1'($urandom);
      l  = (n % 4 == 3) && (s != e);
      ab = l ? $urandom_range(1, 30) : ((n % 5 == 4) ? 1 : 0);
      test_sweep("random", s, e, st, dw, t, l, ab, $urandom_range(0, 255));
    end
  endtask

  task automatic test_reset_mid();
    start_param = 8'd10; stop_param = 8'd30; step = 8'd10; dwell_cycles = 24'd4;
    loop_en = 1'b0; tri_en = 1'b1; manual_param = 8'd123; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (6) @(posedge clk_in);
    #1;
    checks++;
    if (busy !== 1'b1 || freq_param !== 8'd20) begin
      errors++; $display("FAIL reset_mid_pre got busy %b code %0d want 1 20", busy, freq_param);
    end
    reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    checks++;
    if (freq_param !== 8'd0 || {busy, done, param_strobe, dir_down} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid got code %0d flags %b want 0 0000", freq_param,
                         {busy, done, param_strobe, dir_down});
    end
    @(posedge clk_in); #1;
    checks++;
    if (freq_param !== 8'd123 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle got code %0d busy %b done %b want 123 0 0", freq_param, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_loop_abort();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
